// File: rtl/afifo_rd_unpack.sv
// Read-domain drain for the dual-clock FIFO: pops show-ahead DW-bit words and
// emits each one as DW/OW consecutive OW-bit beats on a valid/ready stream.
module afifo_rd_unpack #(
  parameter int DW        = 128,
  parameter int OW        = 32,
  parameter int LSB_FIRST = 1
) (
  input  logic          rclk,
  input  logic          rreset,
  input  logic          rempty,
  input  logic [DW-1:0] q,
  output logic          re,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last,
  output logic [31:0]   word_cnt
);

  localparam int R    = DW / OW;
  localparam int IW   = (R > 1) ? $clog2(R) : 1;
  localparam int OFFW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_hold;
  logic [IW-1:0]   r_idx;
  logic [31:0]     r_word_cnt;
  logic            w_hold_v;
  logic            w_acc;
  logic            w_done;
  logic            w_load;
  logic [OFFW-1:0] w_off;

  assign w_hold_v = (r_state == ST_STREAM);
  assign w_acc    = w_hold_v & m_ready;
  assign w_done   = w_acc & (r_idx == LAST_IDX);
  // Reload coincides with the final-beat accept, so words stream without a bubble.
  assign w_load   = ~rempty & (~w_hold_v | w_done);

  assign re       = w_load & ~rreset;
  assign m_valid  = w_hold_v;
  assign m_last   = w_hold_v & (r_idx == LAST_IDX);
  assign word_cnt = r_word_cnt;

  // Next-state: enter STREAM on a load, fall back to IDLE when a word finishes with nothing to reload.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_done & ~w_load) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat selection: slice r_idx of the holding register in the configured order.
  always_comb begin
    w_off = '0;
    if (LSB_FIRST != 0) begin
      w_off = OFFW'(int'(r_idx) * OW);
    end else begin
      w_off = OFFW'(DW - (int'(r_idx) + 1) * OW);
    end
    m_data = r_hold[w_off +: OW];
  end

  // State, holding register, slice index and word counter.
  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_idx      <= '0;
      r_word_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_hold <= q;
        r_idx  <= '0;
      end else if (w_acc & ~w_done) begin
        r_idx <= r_idx + IW'(1);
      end else if (w_done) begin
        r_idx <= '0;
      end
      if (w_done) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_afifo_rd_unpack.sv
// Directed bench: a queue-based FIFO model feeds two instances (LSB-first and
// MSB-first); expected beats are queued at each modelled pop and checked per cycle.
module tb_afifo_rd_unpack;

  logic         rclk;
  logic         rreset;
  logic         rempty;
  logic [127:0] q;
  logic         m_ready;
  logic         re_l, m_valid_l, m_last_l;
  logic [31:0]  m_data_l, word_cnt_l;
  logic         re_m, m_valid_m, m_last_m;
  logic [31:0]  m_data_m, word_cnt_m;

  logic [127:0] fifo_q[$];
  logic [32:0]  exp_lsb[$];
  logic [32:0]  exp_msb[$];
  logic [31:0]  exp_wc;
  int           n_assert;
  int           n_fail;
  int           acc_cnt;
  int           acc_base;

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] W3 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  afifo_rd_unpack #(.DW(128), .OW(32), .LSB_FIRST(1)) u_lsb (
    .rclk(rclk), .rreset(rreset), .rempty(rempty), .q(q), .re(re_l),
    .m_valid(m_valid_l), .m_ready(m_ready), .m_data(m_data_l),
    .m_last(m_last_l), .word_cnt(word_cnt_l)
  );

  afifo_rd_unpack #(.DW(128), .OW(32), .LSB_FIRST(0)) u_msb (
    .rclk(rclk), .rreset(rreset), .rempty(rempty), .q(q), .re(re_m),
    .m_valid(m_valid_m), .m_ready(m_ready), .m_data(m_data_m),
    .m_last(m_last_m), .word_cnt(word_cnt_m)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    q      = rempty ? 128'd0 : fifo_q[0];
  endtask

  // One cycle: drive inputs after the falling edge, check mid-cycle, update model.
  task automatic step();
    logic         exp_re;
    logic [32:0]  fl;
    logic [32:0]  fm;
    logic [127:0] w;
    drive_fifo();
    #1;
    exp_re = !rempty && (exp_lsb.size() == 0 || (m_ready && exp_lsb[0][32]));
    chk("re_lsb", 64'(re_l), 64'(exp_re));
    chk("re_msb", 64'(re_m), 64'(exp_re));
    chk("valid_lsb", 64'(m_valid_l), 64'(exp_lsb.size() != 0));
    chk("valid_msb", 64'(m_valid_m), 64'(exp_msb.size() != 0));
    chk("wcnt_lsb", 64'(word_cnt_l), 64'(exp_wc));
    chk("wcnt_msb", 64'(word_cnt_m), 64'(exp_wc));
    if (exp_lsb.size() != 0) begin
      fl = exp_lsb[0];
      fm = exp_msb[0];
      chk("data_lsb", 64'(m_data_l), 64'(fl[31:0]));
      chk("last_lsb", 64'(m_last_l), 64'(fl[32]));
      chk("data_msb", 64'(m_data_m), 64'(fm[31:0]));
      chk("last_msb", 64'(m_last_m), 64'(fm[32]));
      if (m_ready) begin
        void'(exp_lsb.pop_front());
        void'(exp_msb.pop_front());
        acc_cnt++;
        if (fl[32]) exp_wc = exp_wc + 32'd1;
      end
    end
    if (exp_re) begin
      w = fifo_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        exp_lsb.push_back({(k == 3), w[k*32 +: 32]});
        exp_msb.push_back({(k == 3), w[127-k*32 -: 32]});
      end
    end
    @(negedge rclk);
  endtask

  task automatic do_reset(input int n);
    rreset = 1'b1;
    exp_lsb.delete();
    exp_msb.delete();
    exp_wc = 32'd0;
    for (int i = 0; i < n; i++) begin
      drive_fifo();
      #1;
      chk("rst_re", 64'({re_l, re_m}), 64'd0);
      chk("rst_valid", 64'({m_valid_l, m_valid_m}), 64'd0);
      chk("rst_last", 64'({m_last_l, m_last_m}), 64'd0);
      chk("rst_data", {m_data_l, m_data_m}, 64'd0);
      chk("rst_wcnt", {word_cnt_l, word_cnt_m}, 64'd0);
      @(negedge rclk);
    end
    rreset = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    acc_cnt  = 0;
    exp_wc   = 32'd0;
    rreset   = 1'b1;
    m_ready  = 1'b0;
    rempty   = 1'b1;
    q        = 128'd0;
    @(negedge rclk);

    // Reset held with FIFO non-empty, then a single word at full rate.
    fifo_q.push_back(W1);
    do_reset(3);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("wcnt_single", 64'(word_cnt_l), 64'd1);

    // Two words back to back: eight contiguous beats.
    fifo_q.push_back(W2);
    fifo_q.push_back(W3);
    step();
    acc_base = acc_cnt;
    for (int i = 0; i < 8; i++) step();
    chk("contig_beats", 64'(acc_cnt - acc_base), 64'd8);
    step();
    chk("wcnt_two", 64'(word_cnt_l), 64'd3);

    // Backpressure on beat 2 with another word waiting in the FIFO.
    fifo_q.push_back(W1);
    fifo_q.push_back(W2);
    step();
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_hold_data", 64'(m_data_l), 64'h22222222);
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();

    // Random ready toggling over random words, then drain.
    for (int i = 0; i < 3; i++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 30; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("drained", 64'(exp_lsb.size()), 64'd0);

    // Reset after two beats of word A while word B is queued.
    fifo_q.push_back(W3);
    fifo_q.push_back(W1);
    for (int i = 0; i < 3; i++) step();
    do_reset(2);
    for (int i = 0; i < 6; i++) step();
    chk("wcnt_after_rst", 64'(word_cnt_l), 64'd1);
    chk("fifo_empty_end", 64'(fifo_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
